// File: rtl/counter_run_ctrl.sv
// Run sequencer for the up/down counter datapath: loads a start value, then steps
// the count toward a captured terminal value at a prescaled rate, with pause/abort.
module counter_run_ctrl #(
  parameter int BITS  = 4,
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             select,
  input  logic [BITS-1:0]  init,
  input  logic [BITS-1:0]  limit,
  input  logic [DIV_W-1:0] div,
  input  logic             pause,
  input  logic             abort,
  output logic [BITS-1:0]  count,
  output logic             busy,
  output logic             tick,
  output logic             done
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [BITS-1:0]  CNT_ONE = BITS'(1);
  localparam logic [DIV_W-1:0] PRE_ONE = DIV_W'(1);

  state_t           state_q, state_d;
  logic [BITS-1:0]  count_q, count_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic             select_q, select_d;
  logic [BITS-1:0]  limit_q, limit_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             busy_q, busy_d;
  logic             tick_q, tick_d;
  logic             done_q, done_d;
  logic [BITS-1:0]  step_val;

  // Next count value in the captured direction; wraps naturally mod 2^BITS.
  assign step_val = select_q ? (count_q - CNT_ONE) : (count_q + CNT_ONE);

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    presc_d  = presc_q;
    select_d = select_q;
    limit_d  = limit_q;
    div_d    = div_q;
    tick_d   = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          select_d = select;
          limit_d  = limit;
          div_d    = div;
          count_d  = init;
          presc_d  = '0;
          if (init == limit) begin
            done_d = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (!pause) begin
          if (presc_q == div_q) begin
            presc_d = '0;
            count_d = step_val;
            tick_d  = 1'b1;
            // Final step: done, tick and the busy drop land on the same edge.
            if (step_val == limit_q) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            presc_d = presc_q + PRE_ONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      presc_q  <= '0;
      select_q <= 1'b0;
      limit_q  <= '0;
      div_q    <= '0;
      busy_q   <= 1'b0;
      tick_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      presc_q  <= presc_d;
      select_q <= select_d;
      limit_q  <= limit_d;
      div_q    <= div_d;
      busy_q   <= busy_d;
      tick_q   <= tick_d;
      done_q   <= done_d;
    end
  end

  assign count = count_q;
  assign busy  = busy_q;
  assign tick  = tick_q;
  assign done  = done_q;

endmodule

// File: tb/tb_counter_run_ctrl.sv
// Scoreboard bench for counter_run_ctrl: a run-level reference model predicts every
// observable output change; a monitor matches them against the DUT edge by edge.
module tb_counter_run_ctrl;

  logic       clk, rst, start, select, pause, abort;
  logic [3:0] init, limit, count;
  logic [7:0] div;
  logic       busy, tick, done;

  counter_run_ctrl #(.BITS(4), .DIV_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .select(select), .init(init),
    .limit(limit), .div(div), .pause(pause), .abort(abort),
    .count(count), .busy(busy), .tick(tick), .done(done)
  );

  typedef struct {
    int         cyc;
    logic [3:0] count;
    logic       tick;
    logic       done;
    logic       busy;
  } ev_t;

  ev_t exp_q[$];
  int  tests = 0;
  int  fails = 0;
  int  cyc = 0;

  // Reference model: a run is "k steps taken out of n", step k lands after
  // k*(div+1) unpaused RUN cycles and shows init +/- k.
  logic       m_busy = 0;
  logic [3:0] m_count = 0;
  logic [3:0] m_init = 0;
  logic       m_dir = 0;
  int         m_div = 0;
  int         m_active = 0;
  int         m_k = 0;
  int         m_steps = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [3:0] c, input logic t, input logic d, input logic b);
    ev_t e;
    e.cyc = cyc + 1;
    e.count = c;
    e.tick = t;
    e.done = d;
    e.busy = b;
    exp_q.push_back(e);
  endtask

  // Drive one cycle of inputs, predict the coming edge, advance to the next negedge.
  task automatic cycle(input logic st, input logic sel, input logic [3:0] i,
                       input logic [3:0] l, input logic [7:0] d,
                       input logic p, input logic a);
    start = st; select = sel; init = i; limit = l; div = d; pause = p; abort = a;
    if (!m_busy) begin
      if (st && !a) begin
        m_count = i;
        if (i == l) begin
          push(i, 1'b0, 1'b1, 1'b0);
        end else begin
          m_busy = 1; m_init = i; m_dir = sel; m_div = int'(d);
          m_active = 0; m_k = 0;
          m_steps = sel ? ((int'(i) - int'(l) + 16) % 16) : ((int'(l) - int'(i) + 16) % 16);
          push(i, 1'b0, 1'b0, 1'b1);
        end
      end
    end else if (a) begin
      m_busy = 0;
      push(m_count, 1'b0, 1'b0, 1'b0);
    end else if (!p) begin
      m_active++;
      if (m_active % (m_div + 1) == 0) begin
        m_k++;
        m_count = m_dir ? 4'((int'(m_init) - m_k + 16) % 16) : 4'((int'(m_init) + m_k) % 16);
        if (m_k == m_steps) m_busy = 0;
        push(m_count, 1'b1, !m_busy, m_busy);
      end
    end
    @(negedge clk);
  endtask

  task automatic cycle_rand(input logic st, input logic p, input logic a);
    cycle(st, 1'($urandom), 4'($urandom), 4'($urandom), 8'($urandom), p, a);
  endtask

  task automatic finish_run(input int pause_pct, input int abort_pct, input int start_pct);
    int guard = 0;
    while (m_busy && guard < 5000) begin
      cycle_rand(($urandom % 100) < start_pct, ($urandom % 100) < pause_pct,
                 ($urandom % 100) < abort_pct);
      guard++;
    end
    if (m_busy) begin
      tests++; fails++;
      $display("FAIL run_bound: run still busy after %0d cycles, required idle", guard);
      m_busy = 0;
    end
  endtask

  // Monitor: any visible change on the DUT must match the oldest expected event.
  initial begin
    logic [3:0] prev_count = 0;
    logic       prev_busy = 0;
    ev_t        e;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        prev_count = 0;
        prev_busy = 0;
      end else begin
        if (tick || done || busy != prev_busy || count != prev_count) begin
          if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_event: count=%0d tick=%0d done=%0d busy=%0d, required no change (cycle %0d)",
                     count, tick, done, busy, cyc);
          end else begin
            e = exp_q.pop_front();
            check("event_cycle", cyc, e.cyc);
            check("count", int'(count), int'(e.count));
            check("tick", int'(tick), int'(e.tick));
            check("done", int'(done), int'(e.done));
            check("busy", int'(busy), int'(e.busy));
          end
        end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
          e = exp_q.pop_front();
          tests++; fails++;
          $display("FAIL missing_event: no change seen, required count=%0d tick=%0d done=%0d busy=%0d at cycle %0d",
                   e.count, e.tick, e.done, e.busy, e.cyc);
        end
        prev_count = count;
        prev_busy = busy;
      end
    end
  end

  initial begin
    rst = 1; start = 0; select = 0; init = 0; limit = 0; div = 0; pause = 0; abort = 0;
    #2;
    check("reset_count", int'(count), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_tick", int'(tick), 0);
    check("reset_done", int'(done), 0);
    @(negedge clk);
    rst = 0;
    cycle_rand(0, 0, 0);

    // Up run 3->7, no prescale.
    cycle(1, 0, 4'd3, 4'd7, 8'd0, 0, 0);
    finish_run(0, 0, 0);
    repeat (2) cycle_rand(0, 0, 0);

    // Down run 1->14 with wrap, div=2.
    cycle(1, 1, 4'd1, 4'd14, 8'd2, 0, 0);
    finish_run(0, 0, 0);
    cycle_rand(0, 0, 0);

    // Pause for four cycles after the second tick.
    cycle(1, 0, 4'd0, 4'd5, 8'd1, 0, 0);
    while (m_busy && m_k < 2) cycle_rand(0, 0, 0);
    repeat (4) cycle_rand(0, 1, 0);
    finish_run(0, 0, 0);
    cycle_rand(0, 0, 0);

    // Abort when count reaches 4, then a fresh 0->2 run.
    cycle(1, 0, 4'd0, 4'd9, 8'd0, 0, 0);
    while (m_busy && m_count != 4'd4) cycle_rand(0, 0, 0);
    cycle_rand(0, 0, 1);
    repeat (2) cycle_rand(0, 0, 0);
    cycle(1, 0, 4'd0, 4'd2, 8'd0, 0, 0);
    finish_run(0, 0, 0);

    // Degenerate run, then a start ignored mid-run.
    cycle(1, 0, 4'd6, 4'd6, 8'd0, 0, 0);
    repeat (2) cycle_rand(0, 0, 0);
    cycle(1, 0, 4'd0, 4'd3, 8'd1, 0, 0);
    repeat (2) cycle_rand(0, 0, 0);
    cycle(1, 0, 4'd9, 4'd1, 8'd0, 0, 0);
    finish_run(0, 0, 0);

    // Start together with abort in IDLE is ignored.
    cycle(1, 0, 4'd2, 4'd8, 8'd0, 0, 1);
    cycle_rand(0, 0, 0);

    // Async reset between edges during a run.
    cycle(1, 0, 4'd0, 4'd15, 8'd1, 0, 0);
    repeat (5) cycle_rand(0, 0, 0);
    start = 0; abort = 0; pause = 1;
    @(posedge clk);
    #2;
    rst = 1;
    #1;
    check("async_rst_count", int'(count), 0);
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_tick", int'(tick), 0);
    check("async_rst_done", int'(done), 0);
    exp_q.delete();
    m_busy = 0; m_count = 0;
    @(negedge clk);
    pause = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    cycle(1, 0, 4'd2, 4'd5, 8'd0, 0, 0);
    finish_run(0, 0, 0);

    // Randomized runs with random pause, abort and ignored starts.
    for (int r = 0; r < 40; r++) begin
      cycle(1, 1'($urandom), 4'($urandom), 4'($urandom), 8'($urandom_range(3, 0)), 0, 0);
      finish_run(20, 3, 10);
      repeat ($urandom_range(2, 0)) cycle_rand(($urandom % 4) == 0, 0, 1);
    end

    repeat (3) cycle_rand(0, 0, 0);
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
